// File: rtl/spike_window_counter.sv
// spike_window_counter
// Counts rising edges on each spike channel over a programmable window of
// clock cycles. When a window ends, the per-channel counts and saturation
// flags are latched and frame_valid pulses for one cycle. Windows run
// back-to-back while enable stays high. Latched counts are read one channel
// at a time through the rd_sel mux.
module spike_window_counter #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int WIN_W = 8,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIN_W-1:0] win_len,
    input  logic [N_CH-1:0]  spike_in,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] count_out,
    output logic [N_CH-1:0]  overflow_out,
    output logic             frame_valid,
    output logic             busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // win_len == 0 selects the longest window, 2^WIN_W cycles.
    localparam logic [WIN_W:0]   WIN_FULL = {1'b1, {WIN_W{1'b0}}};
    localparam logic [WIN_W:0]   TIMER_LAST = {{WIN_W{1'b0}}, 1'b1};

    logic [0:0]       state;
    logic [WIN_W:0]   timer;
    logic [N_CH-1:0]  prev_spike;
    logic [N_CH-1:0]  spike_edge;
    logic [N_CH-1:0]  live_ovf;
    logic [N_CH-1:0]  latched_ovf;
    logic [CNT_W-1:0] live_cnt    [N_CH];
    logic [CNT_W-1:0] latched_cnt [N_CH];
    logic [CNT_W-1:0] next_cnt    [N_CH];
    logic [N_CH-1:0]  next_ovf;
    logic [WIN_W:0]   reload_len;
    logic             last_cycle;

    assign spike_edge   = spike_in & ~prev_spike;
    assign reload_len   = (win_len == '0) ? WIN_FULL : {1'b0, win_len};
    assign last_cycle   = (timer == TIMER_LAST);
    assign busy         = (state == COUNT);
    assign overflow_out = latched_ovf;

    // Saturating per-channel increment, including the edge of the current cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        next_ovf = live_ovf;
        for (int i = 0; i < N_CH; i++) begin
            next_cnt[i] = live_cnt[i];
            if (spike_edge[i]) begin
                if (live_cnt[i] == CNT_MAX) begin
                    next_ovf[i] = 1'b1;
                end else begin
                    next_cnt[i] = live_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Window FSM, live counters, timer and the latched frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            prev_spike  <= '0;
            live_ovf    <= '0;
            latched_ovf <= '0;
            frame_valid <= 1'b0;
            // NOTE: the count arrays are real registers with a defined reset
            // value (readable on count_out), so they are cleared here too.
            for (int i = 0; i < N_CH; i++) begin
                live_cnt[i]    <= '0;
                latched_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge values regardless of statement order.
            prev_spike  <= spike_in;
            frame_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= COUNT;
                        timer <= reload_len;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        // Abort: drop the partial window, keep the last frame.
                        state    <= IDLE;
                        timer    <= '0;
                        live_ovf <= '0;
                        for (int i = 0; i < N_CH; i++) begin
                            live_cnt[i] <= '0;
                        end
                    end else if (last_cycle) begin
                        // Close the window and start the next one with no gap.
                        latched_ovf <= next_ovf;
                        frame_valid <= 1'b1;
                        live_ovf    <= '0;
                        timer       <= reload_len;
                        for (int i = 0; i < N_CH; i++) begin
                            latched_cnt[i] <= next_cnt[i];
                            live_cnt[i]    <= '0;
                        end
                    end else begin
                        live_ovf <= next_ovf;
                        timer    <= timer - 1'b1;
                        for (int i = 0; i < N_CH; i++) begin
                            live_cnt[i] <= next_cnt[i];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Readout mux; selects beyond the last channel read as zero.
    always_comb begin
        count_out = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                count_out = latched_cnt[i];
            end
        end
    end

endmodule

// File: tb/tb_spike_window_counter.sv
// tb_spike_window_counter
// Directed stimulus with hand-computed frames pushed into a scoreboard queue;
// a monitor pops and compares whenever frame_valid is seen, and also services
// explicit state probes (reset / abort checks). Uses CNT_W=4 so saturation is
// reachable, SEL_W=3 so out-of-range selects are exercised.
module tb_spike_window_counter;

    localparam int N_CH  = 4;
    localparam int CNT_W = 4;
    localparam int WIN_W = 8;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIN_W-1:0] win_len;
    logic [N_CH-1:0]  spike_in;
    logic [SEL_W-1:0] rd_sel;
    logic [CNT_W-1:0] count_out;
    logic [N_CH-1:0]  overflow_out;
    logic             frame_valid;
    logic             busy;

    spike_window_counter #(
        .N_CH (N_CH),
        .CNT_W(CNT_W),
        .WIN_W(WIN_W),
        .SEL_W(SEL_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .win_len     (win_len),
        .spike_in    (spike_in),
        .rd_sel      (rd_sel),
        .count_out   (count_out),
        .overflow_out(overflow_out),
        .frame_valid (frame_valid),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    // Cycle label: value after the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cycle;
        logic [15:0] cnts;   // {ch3, ch2, ch1, ch0}
        logic [3:0]  ovf;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t probe_q[$];
    int   probe_issued = 0;
    int   probe_done   = 0;
    int   tests        = 0;
    int   failed       = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Walks rd_sel over every select value and compares the latched frame.
    task automatic check_latched(input string tag, input logic [15:0] cnts, input logic [3:0] ovf);
        int exp_cnt;
        check({tag, "_ovf"}, int'(overflow_out), int'(ovf));
        for (int s = 0; s < 2**SEL_W; s++) begin
            rd_sel = SEL_W'(s);
            #1;
            exp_cnt = (s < N_CH) ? int'(cnts[s*4 +: 4]) : 0;
            check($sformatf("%s_cnt_sel%0d", tag, s), int'(count_out), exp_cnt);
        end
    endtask

    task automatic push_frame(input int at_cyc, input logic [15:0] cnts, input logic [3:0] ovf);
        exp_t e;
        e.cycle = at_cyc;
        e.cnts  = cnts;
        e.ovf   = ovf;
        e.busy  = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic probe(input logic [15:0] cnts, input logic [3:0] ovf, input logic exp_busy);
        exp_t e;
        e.cycle = cyc;
        e.cnts  = cnts;
        e.ovf   = ovf;
        e.busy  = exp_busy;
        probe_q.push_back(e);
        probe_issued++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: frames are checked when frame_valid shows up, probes on request.
    initial begin
        exp_t e;
        rd_sel = '0;
        forever begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_cycle", cyc, e.cycle);
                    check("frame_busy", int'(busy), int'(e.busy));
                    check_latched("frame", e.cnts, e.ovf);
                end
            end else if (probe_done < probe_issued) begin
                e = probe_q.pop_front();
                probe_done++;
                check("probe_busy", int'(busy), int'(e.busy));
                check("probe_frame_valid", int'(frame_valid), 0);
                check_latched("probe", e.cnts, e.ovf);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    int base;

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        win_len  = '0;
        spike_in = '0;
        step(3);
        reset = 1'b0;
        step(1);
        probe(16'h0000, 4'b0000, 1'b0);
        step(2);

        // A: win_len=10, ch0 toggles from window cycle 1 -> 5 edges.
        base = cyc; win_len = 8'd10; enable = 1'b1; spike_in = '0;
        push_frame(base + 11, 16'h0005, 4'b0000);
        step(1);
        for (int j = 1; j <= 10; j++) begin
            spike_in = (j % 2 == 1) ? 4'b0001 : 4'b0000;
            step(1);
        end
        spike_in = '0; enable = 1'b0;
        step(3);

        // B: ch1 held high whole window (1), edge only in last cycle (1), held (0).
        base = cyc; win_len = 8'd8; enable = 1'b1; spike_in = '0;
        push_frame(base + 9,  16'h0010, 4'b0000);
        push_frame(base + 17, 16'h0010, 4'b0000);
        push_frame(base + 25, 16'h0000, 4'b0000);
        step(1);
        for (int j = 1; j <= 24; j++) begin
            spike_in = (j <= 8 || j >= 16) ? 4'b0010 : 4'b0000;
            step(1);
        end
        spike_in = '0; enable = 1'b0;
        step(3);

        // C: win_len=40. ch2 20 edges -> 15 + ovf; ch3 15 edges -> 15, no ovf;
        // ch0 16th edge in the last cycle -> 15 + ovf. Then a quiet frame.
        base = cyc; win_len = 8'd40; enable = 1'b1; spike_in = '0;
        push_frame(base + 41, 16'hFF0F, 4'b0101);
        push_frame(base + 81, 16'h0000, 4'b0000);
        step(1);
        for (int j = 1; j <= 80; j++) begin
            spike_in = '0;
            if (j <= 40) begin
                spike_in[0] = ((j % 2 == 1) && (j <= 29)) || (j == 40);
                spike_in[2] = (j % 2 == 1);
                spike_in[3] = (j % 2 == 1) && (j <= 29);
            end
            step(1);
        end
        spike_in = '0; enable = 1'b0;
        step(3);

        // D: win_len=4 windows back-to-back; switch to 6 inside window 2.
        base = cyc; win_len = 8'd4; enable = 1'b1;
        push_frame(base + 5,  16'h0000, 4'b0000);
        push_frame(base + 9,  16'h0000, 4'b0000);
        push_frame(base + 15, 16'h0000, 4'b0000);
        push_frame(base + 21, 16'h0000, 4'b0000);
        step(7);
        win_len = 8'd6;
        step(14);
        enable = 1'b0;
        step(3);

        // E: frame with ch3=2, then an aborted window with 2 edges, then re-enable.
        base = cyc; win_len = 8'd3; enable = 1'b1; spike_in = '0;
        push_frame(base + 4, 16'h2000, 4'b0000);
        step(1);
        for (int j = 1; j <= 3; j++) begin
            spike_in = (j % 2 == 1) ? 4'b1000 : 4'b0000;
            step(1);
        end
        enable = 1'b0; spike_in = '0;
        step(3);
        base = cyc; win_len = 8'd10; enable = 1'b1;
        step(1);
        spike_in = 4'b0001;
        step(1);
        spike_in = 4'b0010;
        step(1);
        enable = 1'b0; spike_in = '0;
        step(1);
        probe(16'h2000, 4'b0000, 1'b0);
        step(3);
        base = cyc; win_len = 8'd4; enable = 1'b1;
        push_frame(base + 5, 16'h0001, 4'b0000);
        step(1);
        spike_in = 4'b0001;
        step(1);
        spike_in = '0;
        step(3);

        // F: reset while window 2 is accumulating clears everything.
        spike_in = 4'b0100;
        step(1);
        reset = 1'b1;
        step(1);
        probe(16'h0000, 4'b0000, 1'b0);
        reset = 1'b0; enable = 1'b0; spike_in = '0;
        step(12);

        check("frames_outstanding", exp_q.size(), 0);
        check("probes_outstanding", probe_issued - probe_done, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
